// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are formed from operands latched at accept and committed when the latency
// counter expires, so the busy window the hazard unit sees matches the class latency.
module multdiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               op_valid;
  logic               op_is_move;
  logic               op_is_div;
  logic               accept;

  logic               mul_signed;
  logic               div_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] res;
  logic               res_we;

  // Decode the incoming request and decide whether it is taken this cycle.
  always_comb begin
    op_valid   = (op != 4'd0) && (op <= OpMsubu);
    op_is_move = (op == OpMthi) || (op == OpMtlo);
    op_is_div  = (op == OpDiv) || (op == OpDivu);
    // A flushed instruction or one arriving while busy never takes effect.
    accept     = start && !busy && !cancel && op_valid;
  end

  // Result datapath, driven only by the latched copies so RUN-time input changes are inert.
  always_comb begin
    mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
    div_signed = (op_q == OpDiv);

    ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product equal the signed/unsigned product.
    prod  = ext_a * ext_b;

    // Signed divide runs on magnitudes; quotient truncates toward zero and the remainder
    // takes the sign of the dividend. Most-negative / -1 falls out as most-negative, rem 0.
    a_neg   = div_signed && a_q[WIDTH-1];
    b_neg   = div_signed && b_q[WIDTH-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    // A zero divisor never commits; a divisor of one keeps the divider defined.
    b_safe  = (b_mag == '0) ? WIDTH'(1) : b_mag;
    quo_mag = a_mag / b_safe;
    rem_mag = a_mag % b_safe;
    quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem     = a_neg ? -rem_mag : rem_mag;

    res    = acc_q;
    res_we = 1'b0;
    case (op_q)
      OpMult, OpMultu: begin
        res    = prod;
        res_we = 1'b1;
      end
      OpMadd, OpMaddu: begin
        res    = acc_q + prod;
        res_we = 1'b1;
      end
      OpMsub, OpMsubu: begin
        res    = acc_q - prod;
        res_we = 1'b1;
      end
      OpDiv, OpDivu: begin
        res    = {rem, quo};
        res_we = (b_q != '0);
      end
      default: begin
        res    = acc_q;
        res_we = 1'b0;
      end
    endcase
  end

  // Control FSM plus HI/LO state; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (op_is_move) begin
              if (op == OpMthi) begin
                hi <= a;
              end else begin
                lo <= a;
              end
            end else begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= op;
              acc_q   <= {hi, lo};
              cnt_q   <= op_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
              busy    <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (cnt_q == CntW'(1)) begin
            if (res_we) begin
              hi <= res[2*WIDTH-1:WIDTH];
              lo <= res[WIDTH-1:0];
            end
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a default 32-bit instance and a 16-bit, 1/3-cycle
// instance, with hand-computed expectations and a small 16-bit reference model.
module tb_multdiv_unit;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  logic        clk;
  logic        reset;
  logic        start32;
  logic        start16;
  logic        cancel;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy32;
  logic        done32;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic        busy16;
  logic        done16;
  logic [15:0] hi16;
  logic [15:0] lo16;

  int          n_checks;
  int          n_fail;
  logic [15:0] hi_m;
  logic [15:0] lo_m;
  logic [3:0]  ops [8];

  multdiv_unit dut32 (
    .clk    (clk),
    .reset  (reset),
    .start  (start32),
    .op     (op),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy32),
    .done   (done32),
    .hi     (hi32),
    .lo     (lo32)
  );

  multdiv_unit #(
    .WIDTH       (16),
    .MULT_CYCLES (1),
    .DIV_CYCLES  (3)
  ) dut16 (
    .clk    (clk),
    .reset  (reset),
    .start  (start16),
    .op     (op),
    .cancel (cancel),
    .a      (a[15:0]),
    .b      (b[15:0]),
    .busy   (busy16),
    .done   (done16),
    .hi     (hi16),
    .lo     (lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The pipeline never issues a start while the unit is busy.
  always @(posedge clk) begin
    if (!reset && start32) check_eq("start32 while busy", {63'h0, busy32}, 64'h0);
    if (!reset && start16) check_eq("start16 while busy", {63'h0, busy16}, 64'h0);
  end

  function automatic logic obs_busy(input bit w16);
    return w16 ? busy16 : busy32;
  endfunction

  function automatic logic obs_done(input bit w16);
    return w16 ? done16 : done32;
  endfunction

  function automatic logic [31:0] obs_hi(input bit w16);
    return w16 ? {16'h0, hi16} : hi32;
  endfunction

  function automatic logic [31:0] obs_lo(input bit w16);
    return w16 ? {16'h0, lo16} : lo32;
  endfunction

  task automatic set_start(input bit w16, input logic v);
    if (w16) start16 = v;
    else start32 = v;
  endtask

  // Independent 16-bit model built on 32-bit integer arithmetic.
  function automatic logic [31:0] model16(input logic [3:0] o, input logic [15:0] x,
                                          input logic [15:0] y, input logic [31:0] acc);
    int          sx;
    int          sy;
    logic [31:0] ps;
    logic [31:0] pu;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ps = 32'(sx * sy);
    pu = {16'h0, x} * {16'h0, y};
    case (o)
      OpMult:  return ps;
      OpMultu: return pu;
      OpMadd:  return acc + ps;
      OpMaddu: return acc + pu;
      OpMsub:  return acc - ps;
      OpMsubu: return acc - pu;
      OpDiv:   return (y == 16'h0) ? acc : {16'(sx % sy), 16'(sx / sy)};
      OpDivu:  return (y == 16'h0) ? acc : {x % y, x / y};
      default: return acc;
    endcase
  endfunction

  // Issue a multi-cycle op at the current negedge, count busy cycles, check the result.
  // Ends on the done cycle so a following call issues back-to-back.
  task automatic run_op(input bit w16, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit disturb, input string tag);
    int n;
    n  = 0;
    op = o;
    a  = x;
    b  = y;
    set_start(w16, 1'b1);
    @(negedge clk);
    set_start(w16, 1'b0);
    op = 4'd0;
    while (obs_busy(w16) && n < 100) begin
      n++;
      if (disturb && n == 2) begin
        cancel = 1'b1;
        op     = OpDivu;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0;
      end else begin
        cancel = 1'b0;
      end
      @(negedge clk);
    end
    cancel = 1'b0;
    check_eq({tag, " busy cycles"}, 64'(n), 64'(exp_cyc));
    check_eq({tag, " done"}, {63'h0, obs_done(w16)}, 64'h1);
    check_eq({tag, " hi"}, {32'h0, obs_hi(w16)}, {32'h0, exp_hi});
    check_eq({tag, " lo"}, {32'h0, obs_lo(w16)}, {32'h0, exp_lo});
  endtask

  task automatic move_op(input bit w16, input logic [3:0] o, input logic [31:0] x,
                         input string tag);
    op = o;
    a  = x;
    set_start(w16, 1'b1);
    @(negedge clk);
    set_start(w16, 1'b0);
    op = 4'd0;
    check_eq({tag, " busy"}, {63'h0, obs_busy(w16)}, 64'h0);
    check_eq({tag, " done"}, {63'h0, obs_done(w16)}, 64'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start32  = 1'b0;
    start16  = 1'b0;
    cancel   = 1'b0;
    op       = 4'd0;
    a        = 32'h0;
    b        = 32'h0;
    ops      = '{OpMult, OpMultu, OpDiv, OpDivu, OpMadd, OpMaddu, OpMsub, OpMsubu};

    @(negedge clk);
    reset = 1'b0;
    check_eq("reset hi", {32'h0, hi32}, 64'h0);
    check_eq("reset lo", {32'h0, lo32}, 64'h0);
    check_eq("reset busy", {63'h0, busy32}, 64'h0);
    check_eq("reset done", {63'h0, done32}, 64'h0);

    // 32-bit instance, default latencies.
    run_op(1'b0, OpMult, 32'hFFFF_FFFE, 32'h3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult");
    run_op(1'b0, OpMultu, 32'hFFFF_FFFE, 32'h3, 5, 32'h2, 32'hFFFF_FFFA, 1'b0, "multu");
    run_op(1'b0, OpDiv, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div");
    run_op(1'b0, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0,
           "div minneg");
    run_op(1'b0, OpDivu, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, "divu");
    run_op(1'b0, OpDiv, 32'd5, 32'd0, 10, 32'd2, 32'd14, 1'b0, "div by zero");

    move_op(1'b0, OpMthi, 32'h0, "mthi");
    check_eq("mthi hi", {32'h0, hi32}, 64'h0);
    move_op(1'b0, OpMtlo, 32'hFFFF_FFFF, "mtlo");
    check_eq("mtlo lo", {32'h0, lo32}, 64'hFFFF_FFFF);
    check_eq("mtlo hi kept", {32'h0, hi32}, 64'h0);

    run_op(1'b0, OpMaddu, 32'h1, 32'h1, 5, 32'h1, 32'h0, 1'b0, "maddu");
    run_op(1'b0, OpMsub, 32'h2, 32'h1, 5, 32'h0, 32'hFFFF_FFFE, 1'b0, "msub");
    run_op(1'b0, OpMadd, 32'hFFFF_FFFF, 32'h1, 5, 32'h0, 32'hFFFF_FFFD, 1'b0, "madd");
    run_op(1'b0, OpMsubu, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0,
           "msubu");

    // A start from a flushed instruction is dropped.
    op      = OpMult;
    a       = 32'd3;
    b       = 32'd3;
    start32 = 1'b1;
    cancel  = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    cancel  = 1'b0;
    op      = 4'd0;
    check_eq("cancel busy", {63'h0, busy32}, 64'h0);
    @(negedge clk);
    check_eq("cancel busy later", {63'h0, busy32}, 64'h0);
    check_eq("cancel done", {63'h0, done32}, 64'h0);
    check_eq("cancel hi", {32'h0, hi32}, 64'hFFFF_FFFE);
    check_eq("cancel lo", {32'h0, lo32}, 64'hFFFF_FFFF);

    // Cancel and operand churn during RUN leave the in-flight op intact.
    run_op(1'b0, OpMult, 32'd7, 32'd6, 5, 32'h0, 32'd42, 1'b1, "mult disturbed");

    // Reset in the third busy cycle of a divide.
    op      = OpDiv;
    a       = 32'd100;
    b       = 32'd7;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    op      = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre-reset busy", {63'h0, busy32}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midreset busy", {63'h0, busy32}, 64'h0);
    check_eq("midreset done", {63'h0, done32}, 64'h0);
    check_eq("midreset hi", {32'h0, hi32}, 64'h0);
    check_eq("midreset lo", {32'h0, lo32}, 64'h0);

    // 16-bit instance, 1-cycle multiply and 3-cycle divide.
    run_op(1'b1, OpMult, 32'h8000, 32'h8000, 1, 32'h4000, 32'h0, 1'b0, "w16 mult");
    run_op(1'b1, OpDivu, 32'd100, 32'd7, 3, 32'd2, 32'd14, 1'b0, "w16 divu first");
    run_op(1'b1, OpDivu, 32'd1000, 32'd10, 3, 32'd0, 32'd100, 1'b0, "w16 divu b2b");

    move_op(1'b1, OpMthi, 32'h1234, "w16 mthi");
    move_op(1'b1, OpMtlo, 32'hABCD, "w16 mtlo");
    check_eq("w16 mt hi", {48'h0, hi16}, 64'h1234);
    check_eq("w16 mt lo", {48'h0, lo16}, 64'hABCD);
    hi_m = 16'h1234;
    lo_m = 16'hABCD;

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  o;
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] r;
      o = ops[$urandom_range(0, 7)];
      x = 16'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      if (i == 0) begin
        o = OpDiv;
        x = 16'h8000;
        y = 16'hFFFF;
      end
      r = model16(o, x, y, {hi_m, lo_m});
      run_op(1'b1, o, {16'h0, x}, {16'h0, y}, (o == OpDiv || o == OpDivu) ? 3 : 1,
             {16'h0, r[31:16]}, {16'h0, r[15:0]}, 1'b0, $sformatf("sweep%0d", i));
      hi_m = r[31:16];
      lo_m = r[15:0];
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the five-stage pipeline. It generalises operand width and per-class latency. It adds accumulate modes (madd/maddu/msub/msubu) and an exception-cancel input so that a start from an instruction being flushed by an interrupt or exception never takes effect. The hazard unit stalls D on `start | busy` for any HI/LO-using instruction.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MULT_CYCLES`, 5: cycles busy for mult/multu/madd/maddu/msub/msubu; must be ≥ 1.
- `DIV_CYCLES`, 10: cycles busy for div/divu; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  E-stage instruction requests an operation (startmd_E).
- `op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 treated as none.
- `cancel`  in  1  E-stage instruction is being flushed (exception/interrupt entry) this cycle.
- `a`  in  WIDTH  rs operand, after forwarding.
- `b`  in  WIDTH  rt operand, after forwarding.
- `busy`  out  WIDTH-independent 1  an operation is in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are committed.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **Accept condition:** `start & ~busy & ~cancel` and `op` is valid (1–10). All other combinations are no-ops.
- **mthi/mtlo** (op 5/6): on accept, `hi` (or `lo`) ← `a` at that edge. No busy cycle and no done pulse.
- **Multi-cycle ops:** on accept, latch `a`, `b`, `op`, and any accumulate base {hi,lo}. Load the counter with the class latency and set `busy`. No other state changes until commit.
- **States:** IDLE and RUN.
  - IDLE → RUN on accept of a multi-cycle op.
  - RUN counts down each cycle. On the final count, commit HI/LO, clear `busy`, and return to IDLE.
- **mult:** signed WIDTH×WIDTH gives a 2·WIDTH product; `hi` = upper half, `lo` = lower half.
- **multu:** same as mult, unsigned.
- **madd/maddu:** {hi,lo} ← {hi,lo} + product, 2·WIDTH wrap-around, signed or unsigned product respectively.
- **msub/msubu:** {hi,lo} ← {hi,lo} − product, 2·WIDTH wrap-around.
- **div:** `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - Most-negative / −1: `lo` = most-negative value, `hi` = 0.
- **divu:** unsigned quotient and remainder.
- **Divide by zero (div/divu):** `hi` and `lo` are left unchanged, but `busy` is still held for the full DIV_CYCLES.
- **Operand isolation:** changes on `a`/`b`/`op` during RUN have no effect, because the latched copies are used.
- **`start` while busy:** ignored. The hazard unit never issues this; the bench flags it as an assertion.
- **`cancel` during RUN:** does not abort the in-flight operation. `cancel` only gates acceptance in its own cycle.
- **reset:** asserted in any state, it returns the unit to IDLE and clears `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, and the counter. An in-flight result is discarded.

## Timing
- Accept at edge k for a class with latency L: `busy` = 1 for cycles k+1 … k+L; `hi`/`lo` hold new values from edge k+L; `busy` = 0 and `done` = 1 in cycle k+L+1.
  - Correction to the line above: `hi`/`lo` update and `busy` falls at the same edge, k+L. `done` is high for the single cycle following edge k+L.
- `hi`/`lo` are stable and readable (for mfhi/mflo in E) whenever `busy` = 0.
- A new op may be accepted in the same cycle `busy` is observed 0, including the cycle `done` = 1, giving back-to-back operation with no bubble.
- mthi/mtlo: result visible the cycle after the accept edge.

## Test plan
- **Reset:** reset one cycle → `hi` = `lo` = 0, `busy` = 0, `done` = 0. Then reset asserted mid-div (3rd busy cycle) → `busy` = 0 next cycle and `hi`/`lo` = 0.
- **mult (default params):** a = 0xFFFFFFFE (−2), b = 3, mult → `busy` high exactly 5 cycles, then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA. Same operands with multu → `hi` = 0x00000002, `lo` = 0xFFFFFFFA.
- **div:**
  - a = −7 (0xFFFFFFF9), b = 2, div → after 10 busy cycles, `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - a = 0x80000000, b = 0xFFFFFFFF, div → `lo` = 0x80000000, `hi` = 0.
  - b = 0 → `hi`/`lo` unchanged, `busy` still high 10 cycles.
- **Accumulate:** mthi 0, mtlo 0xFFFFFFFF, then maddu a = 1, b = 1 → `hi` = 1, `lo` = 0. Then msub a = 2, b = 1 → `hi` = 0, `lo` = 0xFFFFFFFE.
- **Cancel:** start = 1, cancel = 1, op = mult → `busy` stays 0 and HI/LO unchanged. Start mult, then assert cancel during RUN → result still commits after 5 cycles.
- **Parametrisation:** WIDTH = 16, MULT_CYCLES = 1, DIV_CYCLES = 3.
  - mult 0x8000×0x8000 → `hi` = 0x4000, `lo` = 0x0000 after 1 busy cycle.
  - Back-to-back divu accepted on the `done` cycle → no idle gap.
  - Random operand sweep compared against a reference model.
